// File: rtl/uv_bus_slice_if.sv
// Native request/response bus bundle. The master drives requests and accepts
// responses; the slave accepts requests and drives responses.
interface uv_bus_slice_if #(
  parameter int ALEN = 12,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8
);
  logic            req_vld;
  logic            req_rdy;
  logic            req_read;
  logic [ALEN-1:0] req_addr;
  logic [MLEN-1:0] req_mask;
  logic [DLEN-1:0] req_data;

  logic            rsp_vld;
  logic            rsp_rdy;
  logic [1:0]      rsp_excp;
  logic [DLEN-1:0] rsp_data;

  modport master (
    output req_vld, req_read, req_addr, req_mask, req_data,
    input  req_rdy,
    input  rsp_vld, rsp_excp, rsp_data,
    output rsp_rdy
  );

  modport slave (
    input  req_vld, req_read, req_addr, req_mask, req_data,
    output req_rdy,
    output rsp_vld, rsp_excp, rsp_data,
    input  rsp_rdy
  );
endinterface

// File: rtl/uv_bus_slice.sv
// Bidirectional register slice: each channel is a 2-entry skid buffer with a
// registered ready, so no combinational path crosses the slice.

module uv_bus_slice_chan #(
  parameter int W     = 8,
  parameter bit SLICE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  generate
    if (SLICE) begin : g_reg
      logic         main_vld_reg, main_vld_next;
      logic [W-1:0] main_data_reg, main_data_next;
      logic         skid_vld_reg, skid_vld_next;
      logic [W-1:0] skid_data_reg, skid_data_next;
      logic         in_rdy_reg;
      logic         in_fire, out_fire, main_free;

      assign in_fire   = in_vld & in_rdy_reg;
      assign out_fire  = main_vld_reg & out_rdy;
      assign main_free = ~main_vld_reg | out_fire;

      // Skid data always drains into main before newer input, keeping FIFO order.
      always_comb begin
        main_vld_next  = main_vld_reg;
        main_data_next = main_data_reg;
        skid_vld_next  = skid_vld_reg;
        skid_data_next = skid_data_reg;
        if (main_free) begin
          if (skid_vld_reg) begin
            main_vld_next  = 1'b1;
            main_data_next = skid_data_reg;
            skid_vld_next  = in_fire;
            if (in_fire) begin
              skid_data_next = in_data;
            end
          end else begin
            main_vld_next = in_fire;
            if (in_fire) begin
              main_data_next = in_data;
            end
          end
        end else if (in_fire) begin
          skid_vld_next  = 1'b1;
          skid_data_next = in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          main_vld_reg  <= 1'b0;
          main_data_reg <= '0;
          skid_vld_reg  <= 1'b0;
          skid_data_reg <= '0;
          in_rdy_reg    <= 1'b0;
        end else begin
          main_vld_reg  <= main_vld_next;
          main_data_reg <= main_data_next;
          skid_vld_reg  <= skid_vld_next;
          skid_data_reg <= skid_data_next;
          in_rdy_reg    <= ~skid_vld_next;
        end
      end

      assign in_rdy   = in_rdy_reg;
      assign out_vld  = main_vld_reg;
      assign out_data = main_data_reg;
    end else begin : g_pass
      // Pass-through channel carries no state, so clock and reset go unused.
      logic unused_pass;
      assign unused_pass = clk ^ rst;

      assign in_rdy   = out_rdy;
      assign out_vld  = in_vld;
      assign out_data = in_data;
    end
  endgenerate
endmodule

module uv_bus_slice #(
  parameter int ALEN      = 12,
  parameter int DLEN      = 32,
  parameter int MLEN      = DLEN / 8,
  parameter bit REQ_SLICE = 1'b1,
  parameter bit RSP_SLICE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  uv_bus_slice_if.slave  s,
  uv_bus_slice_if.master m
);
  localparam int REQ_W = 1 + ALEN + MLEN + DLEN;
  localparam int RSP_W = 2 + DLEN;

  logic [REQ_W-1:0] req_in, req_out;
  logic [RSP_W-1:0] rsp_in, rsp_out;

  assign req_in = {s.req_read, s.req_addr, s.req_mask, s.req_data};
  assign {m.req_read, m.req_addr, m.req_mask, m.req_data} = req_out;

  assign rsp_in = {m.rsp_excp, m.rsp_data};
  assign {s.rsp_excp, s.rsp_data} = rsp_out;

  uv_bus_slice_chan #(
    .W     (REQ_W),
    .SLICE (REQ_SLICE)
  ) u_req (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (s.req_vld),
    .in_rdy   (s.req_rdy),
    .in_data  (req_in),
    .out_vld  (m.req_vld),
    .out_rdy  (m.req_rdy),
    .out_data (req_out)
  );

  uv_bus_slice_chan #(
    .W     (RSP_W),
    .SLICE (RSP_SLICE)
  ) u_rsp (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (m.rsp_vld),
    .in_rdy   (m.rsp_rdy),
    .in_data  (rsp_in),
    .out_vld  (s.rsp_vld),
    .out_rdy  (s.rsp_rdy),
    .out_data (rsp_out)
  );
endmodule
